// File: rtl/median_pkg.sv
// Shared definitions for the median-cell sequencer.
//   state_t  : sequencer FSM states
//   H        : half window for the default window size
//   cmp_len  : length of compare round k (p-1-k cycles)
//   byp_len  : length of bypass round k (k+1 cycles)
package median_pkg;

  localparam int P_DEF = 9;
  localparam int H     = (P_DEF - 1) / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    BYPS,
    FIN,
    DONE
  } state_t;

  function automatic int cmp_len(input int p, input int k);
    return p - 1 - k;
  endfunction

  function automatic int byp_len(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/median_seq.sv
// Control sequencer for the 9-register median cell.
// Steers the cell through load, compare and bypass rounds, and flags the
// cycle in which the cell output holds the window median.
//   CLK     : clock, rising edge
//   RST     : synchronous reset, active high
//   DSI     : sample strobe, high for P consecutive cycles per window
//   MED_DSI : shift-in strobe to the cell
//   MED_BYP : bypass control to the cell
//   DSO     : one-cycle pulse, cell DO is the median
//   BUSY    : high from load cycle 0 through DONE
module median_seq
  import median_pkg::*;
#(
  parameter int P  = 9,
  parameter int CW = 6
) (
  input  logic CLK,
  input  logic RST,
  input  logic DSI,
  output logic MED_DSI,
  output logic MED_BYP,
  output logic DSO,
  output logic BUSY
);

  localparam int HL = (P - 1) / 2;

  state_t          st, st_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   rnd, rnd_nxt;

  // Last-cycle markers for the timed states of the current round.
  logic cmp_last, byp_last, fin_last, load_last, rnd_last;

  assign cmp_last  = (cnt == CW'(cmp_len(P, int'(rnd)) - 1));
  assign byp_last  = (cnt == CW'(byp_len(int'(rnd)) - 1));
  assign fin_last  = (cnt == CW'(HL - 1));
  assign load_last = (cnt == CW'(P - 1));
  assign rnd_last  = (rnd == CW'(HL - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      st  <= IDLE;
      cnt <= '0;
      rnd <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      rnd <= rnd_nxt;
    end
  end

  // Next state
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    rnd_nxt = rnd;
    case (st)
      IDLE: begin
        // A strobe here is load cycle 0; the LOAD count starts at 1.
        if (DSI) begin
          st_nxt  = LOAD;
          cnt_nxt = CW'(1);
        end
      end
      LOAD: begin
        if (!DSI) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else if (load_last) begin
          st_nxt  = CMP;
          cnt_nxt = '0;
          rnd_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      CMP: begin
        if (cmp_last) begin
          st_nxt  = BYPS;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BYPS: begin
        if (byp_last) begin
          st_nxt  = rnd_last ? FIN : CMP;
          cnt_nxt = '0;
          rnd_nxt = rnd + CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      FIN: begin
        if (fin_last) begin
          st_nxt  = DONE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        // A strobe in DONE starts the next window back-to-back.
        rnd_nxt = '0;
        if (DSI) begin
          st_nxt  = LOAD;
          cnt_nxt = CW'(1);
        end else begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
        rnd_nxt = '0;
      end
    endcase
  end

  // Outputs; strobes arriving during CMP/BYPS/FIN are dropped.
  always_comb begin
    MED_BYP = 1'b1;
    MED_DSI = 1'b0;
    DSO     = 1'b0;
    BUSY    = 1'b0;
    case (st)
      IDLE: begin
        MED_DSI = DSI;
        BUSY    = DSI;
      end
      LOAD: begin
        MED_DSI = DSI;
        BUSY    = 1'b1;
      end
      CMP: begin
        MED_BYP = 1'b0;
        BUSY    = 1'b1;
      end
      BYPS: begin
        BUSY    = 1'b1;
      end
      FIN: begin
        MED_BYP = 1'b0;
        BUSY    = 1'b1;
      end
      DONE: begin
        MED_DSI = DSI;
        DSO     = 1'b1;
        BUSY    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
